// File: rtl/bd_io_pkg.sv
// ---------------------------------------------------------------------------
// bd_io_pkg
// Shared definitions for the FPGA-to-Braindrop I/O link blocks.
//   NBITS_BD_IN        : width of one BD input word
//   *_DEF constants    : default parameter values for the handshaker
//   bd_hs_state_t      : 4-phase bundled-data transmitter state encoding
// ---------------------------------------------------------------------------
package bd_io_pkg;

  localparam int NBITS_BD_IN        = 21;
  localparam int SYNC_STAGES_DEF    = 2;
  localparam int SETUP_CYCLES_DEF   = 1;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } bd_hs_state_t;

endpackage

// File: rtl/bd_sync.sv
// ---------------------------------------------------------------------------
// bd_sync
// N-stage single-bit synchronizer for an asynchronous level input.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output (d delayed by STAGES flops)
// ---------------------------------------------------------------------------
module bd_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/bd_in_handshaker.sv
// ---------------------------------------------------------------------------
// bd_in_handshaker
// Transmitter end of the FPGA-to-Braindrop input link. Accepts words from a
// valid/ready stream and drives them onto the BD input bus with a 4-phase
// bundled-data req/ack handshake. BD_in_ack is asynchronous and is only
// used after the bd_sync synchronizer.
//
// Ports:
//   clk            : internal BD input clock
//   reset          : synchronous, active-high
//   data_in        : word to send (NBITS)
//   valid_in       : data_in valid
//   ready_out      : word can be accepted this cycle
//   BD_in_data     : bundled data to chip (NBITS)
//   BD_in_req      : request to chip
//   BD_in_ack      : acknowledge from chip (asynchronous)
//   busy           : a handshake is in progress
//   words_sent     : completed handshakes, wraps at 2^32
//   timeout_pulse  : (BD_IN_TIMEOUT_EN only) one-cycle phase timeout strobe
//   timeout_sticky : (BD_IN_TIMEOUT_EN only) timeout seen since reset
//
// Optional feature macro: BD_IN_TIMEOUT_EN -- adds a per-phase watchdog that
// abandons a handshake after TIMEOUT_CYCLES cycles in REQ_HI or REQ_LO.
// ---------------------------------------------------------------------------
module bd_in_handshaker
  import bd_io_pkg::*;
#(
  parameter int NBITS          = NBITS_BD_IN,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF
`ifdef BD_IN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [NBITS-1:0] BD_in_data,
  output logic             BD_in_req,
  input  logic             BD_in_ack,
  output logic             busy,
  output logic [31:0]      words_sent
`ifdef BD_IN_TIMEOUT_EN
  ,
  output logic             timeout_pulse,
  output logic             timeout_sticky
`endif
);

  localparam int SCW = $clog2(SETUP_CYCLES + 1);

  bd_hs_state_t   state;
  bd_hs_state_t   state_next;
  logic [SCW-1:0] setup_cnt;
  logic           ack_s;
  logic           accept;
  logic           word_done;
  logic           timeout_hit;

  bd_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (BD_in_ack),
    .q     (ack_s)
  );

  assign accept    = valid_in && ready_out;
  assign word_done = (state == REQ_LO) && !ack_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The ack-driven advance always wins over the watchdog.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        // Counter value 1 means this decrement reaches 0.
        if (setup_cnt == SCW'(1)) state_next = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s)            state_next = REQ_LO;
        else if (timeout_hit) state_next = IDLE;
      end
      REQ_LO: begin
        if (!ack_s)           state_next = IDLE;
        else if (timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode. A stale synchronized ack keeps the stream stalled in IDLE
  // so req can never rise into an ack that is still high.
  always_comb begin
    ready_out = 1'b0;
    if (!reset && (state == IDLE)) ready_out = !ack_s;
    busy = (state != IDLE);
  end

  // Bus registers. req has its own flop so the chip never sees a decode
  // glitch; it is high exactly while the FSM sits in REQ_HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      BD_in_req  <= 1'b0;
      BD_in_data <= '0;
      setup_cnt  <= '0;
      words_sent <= '0;
    end else begin
      BD_in_req <= (state_next == REQ_HI);
      if (accept) begin
        BD_in_data <= data_in;
        setup_cnt  <= SCW'(SETUP_CYCLES);
      end else if (state == SETUP) begin
        setup_cnt <= setup_cnt - SCW'(1);
      end
      if (word_done) words_sent <= words_sent + 32'd1;
    end
  end

`ifdef BD_IN_TIMEOUT_EN
  localparam int PCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [PCW-1:0] phase_cnt;
  logic           waiting;

  // Still waiting on the chip in the current phase.
  assign waiting     = ((state == REQ_HI) && !ack_s) || ((state == REQ_LO) && ack_s);
  assign timeout_hit = waiting && (phase_cnt == PCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt      <= '0;
      timeout_pulse  <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      // Any state change is a phase entry; the count restarts from 0.
      if (state_next != state) begin
        phase_cnt <= '0;
      end else if ((state == REQ_HI) || (state == REQ_LO)) begin
        phase_cnt <= phase_cnt + PCW'(1);
      end
      timeout_pulse <= timeout_hit;
      if (timeout_hit) timeout_sticky <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bd_in_handshaker.sv
`timescale 1ns/1ps
module tb_bd_in_handshaker;

  localparam int NB          = 21;
  localparam int SS          = 2;
  localparam int SC          = 1;
  localparam int MIN_SPACING = SC + 2*SS + 3;
  localparam int WAIT_MAX    = 400;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NB-1:0]  data_in = '0;
  logic           valid_in = 1'b0;
  logic           ready_out;
  logic [NB-1:0]  bd_data;
  logic           bd_req;
  logic           bd_ack = 1'b0;
  logic           busy;
  logic [31:0]    words_sent;
`ifdef BD_IN_TIMEOUT_EN
  logic           timeout_pulse;
  logic           timeout_sticky;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [NB-1:0] exp_q[$];

  bd_in_handshaker #(
    .NBITS          (NB),
    .SYNC_STAGES    (SS),
    .SETUP_CYCLES   (SC)
`ifdef BD_IN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .BD_in_data     (bd_data),
    .BD_in_req      (bd_req),
    .BD_in_ack      (bd_ack),
    .busy           (busy),
    .words_sent     (words_sent)
`ifdef BD_IN_TIMEOUT_EN
    ,
    .timeout_pulse  (timeout_pulse),
    .timeout_sticky (timeout_sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: ack follows req after ack_dly cycles; can be forced high or muted.
  int   ack_dly   = 3;
  int   dcnt      = 0;
  bit   chip_on   = 1'b1;
  bit   ack_force = 1'b0;
  always @(posedge clk) begin
    if (ack_force) begin
      bd_ack <= 1'b1;
      dcnt   <= 0;
    end else if (!chip_on) begin
      bd_ack <= 1'b0;
      dcnt   <= 0;
    end else if (bd_req != bd_ack) begin
      if (dcnt >= ack_dly - 1) begin
        bd_ack <= bd_req;
        dcnt   <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      dcnt <= 0;
    end
  end

  // Reference model of the synchronized ack.
  logic [SS-1:0] ref_sync;
  logic          ref_ack_s;
  always @(posedge clk) begin
    if (reset) ref_sync <= '0;
    else       ref_sync <= {ref_sync[SS-2:0], bd_ack};
  end
  assign ref_ack_s = ref_sync[SS-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: scoreboard pop on each req rise, protocol and stability checks.
  logic          rst_seen = 1'b1;
  logic          acc_seen = 1'b0;
  logic          prev_req = 1'b0;
  logic [NB-1:0] prev_data = '0;
  int            last_rise = -1;
  always @(posedge clk) begin
    rst_seen <= reset;
    acc_seen <= valid_in && ready_out;
  end
  always @(negedge clk) begin
    logic [NB-1:0] e;
    if (bd_req === 1'b1 && prev_req === 1'b0) begin
      check("req_rise_has_word", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("word_order", bd_data, e);
      end
      check("ack_s_low_at_req_rise", ref_ack_s, 0);
      if (last_rise >= 0) check("word_spacing", (cyc - last_rise) >= MIN_SPACING, 1);
      last_rise = cyc;
    end
    if (bd_data !== prev_data) check("data_change_only_on_accept", acc_seen || rst_seen, 1);
    prev_req  = bd_req;
    prev_data = bd_data;
  end

  task automatic send_word(input logic [NB-1:0] w);
    int n = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_bound", n < WAIT_MAX, 1);
    if (n < WAIT_MAX) begin
      exp_q.push_back(w);
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < WAIT_MAX, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] base;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ready_out, 0);
    check("rst_req", bd_req, 0);
    check("rst_data", bd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", ready_out, 1);

    // Single word with exact timing
    send_word(21'h15A5A5);
    check("t1_ready_low", ready_out, 0);
    check("t1_busy", busy, 1);
    check("t1_data", bd_data, 21'h15A5A5);
    check("t1_req_still_low", bd_req, 0);
    @(negedge clk);
    check("t1_req_high", bd_req, 1);
    check("t1_data_held", bd_data, 21'h15A5A5);
    wait_idle("t1_done");
    check("t1_words", words_sent, 1);

    // Back-to-back, valid held high
    base = words_sent;
    for (int i = 0; i < 100; i++) send_word(NB'($urandom));
    wait_idle("b2b_done");
    check("b2b_words", words_sent, base + 32'd100);

    // Upstream stall with random valid toggling and garbage data while busy
    base = words_sent;
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        data_in  = NB'($urandom);
        valid_in = (busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      send_word(NB'($urandom));
    end
    wait_idle("stall_done");
    check("stall_words", words_sent, base + 32'd40);

    // Reset in REQ_HI with the chip holding ack high afterwards
    send_word(21'h0ABCDE);
    n = 0;
    while (bd_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_req_seen", n < 50, 1);
    ack_force = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_mid_req", bd_req, 0);
    check("rst_mid_data", bd_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", ready_out, 0);
    check("rst_mid_words", words_sent, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stale_ack_ready", ready_out, !ref_ack_s);
    end
    check("stale_ack_blocks", ready_out, 0);
    ack_force = 1'b0;
    send_word(21'h13579B);
    wait_idle("post_rst_done");
    check("post_rst_words", words_sent, 1);

    // words_sent wrap
    force dut.words_sent = 32'hFFFF_FFFF;
    #1;
    release dut.words_sent;
    @(negedge clk);
    check("wrap_preload", words_sent, 32'hFFFF_FFFF);
    send_word(21'h1C3C3C);
    wait_idle("wrap_done");
    check("wrap_words", words_sent, 0);

`ifdef BD_IN_TIMEOUT_EN
    // Chip never acks: watchdog abandons the word
    check("to_sticky_clear", timeout_sticky, 0);
    base    = words_sent;
    chip_on = 1'b0;
    send_word(21'h1F0F0F);
    n = 0;
    while (bd_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_req_seen", n < 50, 1);
    n = 0;
    while (bd_req === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_req_high_cycles", n, 16);
    check("to_pulse_on", timeout_pulse, 1);
    check("to_sticky_set", timeout_sticky, 1);
    check("to_busy", busy, 0);
    @(negedge clk);
    check("to_pulse_one_cycle", timeout_pulse, 0);
    check("to_sticky_held", timeout_sticky, 1);
    check("to_words_unchanged", words_sent, base);
    chip_on = 1'b1;
    send_word(21'h0F0F0F);
    wait_idle("to_next_done");
    check("to_next_words", words_sent, base + 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
